led_seq_ctrl: RTL and testbench
===============================

LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 Parameter LED_W, default 4, SHALL set the number of LED outputs; legal range is 2..16.
REQ-002 Parameter DIV, default 25, SHALL set the number of clk cycles per base tick; legal range is 1..2^25.
REQ-003 clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 start_i  input  1  SHALL be a one-cycle strobe that loads mode_i and period_i and runs the sequence.
REQ-006 stop_i  input  1  SHALL be a one-cycle strobe that returns the block to IDLE.
REQ-007 pause_i  input  1  SHALL be a one-cycle strobe that toggles between RUN and PAUSE.
REQ-008 mode_i  input  2  SHALL select the pattern: 0 flow-left, 1 flow-right, 2 blink, 3 ping-pong.
REQ-009 period_i  input  8  SHALL give the number of base ticks per LED step.
REQ-010 led  output  LED_W  SHALL be the registered LED drive, with 1 meaning on.
REQ-011 busy_o  output  1  SHALL be high whenever the state is not IDLE.
REQ-012 step_o  output  1  SHALL be a one-cycle pulse in the same cycle that led takes a new step value.
REQ-013 wrap_o  output  1  SHALL be a one-cycle pulse coincident with the step_o that completes a full pattern cycle.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and PAUSE.
REQ-015 Command priority SHALL be stop_i > start_i > pause_i; only the highest-priority asserted command takes effect in a cycle.
REQ-016 stop_i in any state SHALL give, next cycle: state IDLE, led=0, all counters 0, no step_o or wrap_o.
REQ-017 start_i in any state SHALL, next cycle: latch mode_i and period_i (period_i=0 latched as 1), clear the prescaler and step counter, enter RUN, and load led.
REQ-018 The led load value on start SHALL be 1 (LSB on) for modes 0 and 3, {1'b1,0...} (MSB on) for mode 1, and all-ones for mode 2; the ping-pong direction is set to up.
REQ-019 start_i while in RUN or PAUSE SHALL restart the sequence with the new parameters; changes to mode_i and period_i at any other time SHALL be ignored.
REQ-020 pause_i SHALL move RUN to PAUSE and PAUSE to RUN, and SHALL be ignored in IDLE.
REQ-021 In PAUSE, led, the prescaler and the step counter SHALL hold; on resume, counting continues from the held values.
REQ-022 Prescaler: a 25-bit counter SHALL count 0..DIV-1 and wrap only in RUN; the tick SHALL be high in the cycle where the count equals DIV-1.
REQ-023 Step counter: an 8-bit counter SHALL increment on each tick and wrap at latched period-1; a step event SHALL occur on a tick when the count equals period-1.
REQ-024 On a step event, led and step_o SHALL update in the same registered cycle, as follows:
- mode 0: rotate left, {led[W-2:0], led[W-1]};
- mode 1: rotate right;
- mode 2: invert all bits;
- mode 3: shift one place in the current direction; on reaching the MSB the direction becomes down, on reaching the LSB it becomes up; the end bit is lit for one step only (no double-hold).
REQ-025 wrap_o SHALL assert on the step whose new led value equals the mode's load value:
- after LED_W steps in modes 0 and 1;
- after 2 steps in mode 2;
- after 2*(LED_W-1) steps in mode 3.
REQ-026 Step latency: the first step_o after start SHALL occur exactly DIV*period clk cycles after the cycle in which the start takes effect.
REQ-027 Simultaneous start_i and pause_i SHALL perform the start only, and the resulting state SHALL be RUN.
REQ-028 All outputs SHALL come directly from registers; there is no combinational path from input to output.

Reset
REQ-029 While rst_n=0, the block SHALL hold: state IDLE, led=0, busy_o=0, step_o=0, wrap_o=0, all counters 0, mode=0, period=1, direction up.
REQ-030 On rst_n deassertion, the block SHALL remain in IDLE until start_i; an asserted rst_n mid-RUN SHALL take effect immediately, asynchronously.

Verification
REQ-031 LED_W=4, DIV=2, start mode 0, period 1 -> led 0001, then 0010, 0100, 1000, 0001 at 2-cycle spacing; wrap_o with the 0001 step.
REQ-032 Mode 3, DIV=1, period 1 -> led 0001, 0010, 0100, 1000, 0100, 0010, 0001; wrap_o on the 6th step.
REQ-033 Mode 2, DIV=1, period 0 -> behaves as period 1: led 1111, 0000, 1111 on consecutive cycles; wrap_o every 2nd step.
REQ-034 Mode 0 running, pause_i for 10 cycles, then pause_i again -> led frozen and step_o=0 while paused; the next step comes after the remaining ticks only.
REQ-035 Same-cycle stop_i and start_i in RUN -> IDLE, led=0, busy_o=0 the next cycle.
REQ-036 rst_n pulled low mid-step in mode 1 -> led=0 and busy_o=0 with no clock edge; after release, start mode 1 -> led 1000.

Source files
------------

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl
//   Drives a bank of LEDs through one of four step patterns. The step rate is
//   DIV clk cycles per base tick times a programmable number of ticks per step.
//   The block is controlled by one-cycle command strobes (stop > start > pause).
//
// Parameters
//   LED_W    number of LED outputs (2..16)
//   DIV      clk cycles per base tick (1..2^25)
//
// Ports
//   clk       in   single clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start_i   in   strobe: latch mode_i/period_i, load the pattern, run
//   stop_i    in   strobe: return to IDLE and clear everything
//   pause_i   in   strobe: toggle RUN <-> PAUSE (ignored in IDLE)
//   mode_i    in   0 flow-left, 1 flow-right, 2 blink, 3 ping-pong
//   period_i  in   base ticks per LED step (0 is treated as 1)
//   led       out  registered LED drive, 1 = on
//   busy_o    out  high whenever the state is not IDLE
//   step_o    out  one-cycle pulse with each new led value
//   wrap_o    out  one-cycle pulse on the step that completes a pattern cycle
module led_seq_ctrl #(
  parameter int LED_W = 4,
  parameter int DIV   = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             pause_i,
  input  logic [1:0]       mode_i,
  input  logic [7:0]       period_i,
  output logic [LED_W-1:0] led,
  output logic             busy_o,
  output logic             step_o,
  output logic             wrap_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [24:0] DIV_M1  = 25'(DIV - 1);
  localparam logic        DIR_UP  = 1'b0;
  localparam logic        DIR_DN  = 1'b1;

  state_t             state_q,  state_d;
  logic [1:0]         mode_q,   mode_d;
  logic [7:0]         period_q, period_d;
  logic               dir_q,    dir_d;
  logic [24:0]        presc_q,  presc_d;
  logic [7:0]         cnt_q,    cnt_d;
  logic [LED_W-1:0]   led_q,    led_d;
  logic               busy_q,   busy_d;
  logic               step_q,   step_d;
  logic               wrap_q,   wrap_d;

  logic               tick;
  logic [LED_W-1:0]   nxt_led;
  logic               nxt_dir;

  // Pattern value loaded on start; also the value that marks a completed cycle.
  function automatic logic [LED_W-1:0] load_pattern(input logic [1:0] m);
    logic [LED_W-1:0] v;
    case (m)
      2'd1:    v = {1'b1, {(LED_W-1){1'b0}}};
      2'd2:    v = '1;
      default: v = LED_W'(1);
    endcase
    return v;
  endfunction

  assign tick = (presc_q == DIV_M1);

  // Next led value for the latched mode. Ping-pong flips direction as soon as
  // the lit bit lands on an end, so each end bit is shown for exactly one step.
  always_comb begin
    nxt_led = led_q;
    nxt_dir = dir_q;
    case (mode_q)
      2'd0: nxt_led = {led_q[LED_W-2:0], led_q[LED_W-1]};
      2'd1: nxt_led = {led_q[0], led_q[LED_W-1:1]};
      2'd2: nxt_led = ~led_q;
      default: begin
        if (dir_q == DIR_UP) nxt_led = led_q << 1;
        else                 nxt_led = led_q >> 1;
        if (nxt_led[LED_W-1])  nxt_dir = DIR_DN;
        else if (nxt_led[0])   nxt_dir = DIR_UP;
      end
    endcase
  end

  // Command decode and counters. A command cycle never advances the counters,
  // so a pause or resume strobe takes effect without consuming a clk of count.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    period_d = period_q;
    dir_d    = dir_q;
    presc_d  = presc_q;
    cnt_d    = cnt_q;
    led_d    = led_q;
    step_d   = 1'b0;
    wrap_d   = 1'b0;

    if (stop_i) begin
      state_d = IDLE;
      led_d   = '0;
      presc_d = '0;
      cnt_d   = '0;
    end else if (start_i) begin
      state_d  = RUN;
      mode_d   = mode_i;
      period_d = (period_i == 8'd0) ? 8'd1 : period_i;
      presc_d  = '0;
      cnt_d    = '0;
      led_d    = load_pattern(mode_i);
      dir_d    = DIR_UP;
    end else if (pause_i) begin
      case (state_q)
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = state_q;
      endcase
    end else if (state_q == RUN) begin
      presc_d = tick ? 25'd0 : presc_q + 25'd1;
      if (tick) begin
        if (cnt_q == period_q - 8'd1) begin
          cnt_d  = '0;
          led_d  = nxt_led;
          dir_d  = nxt_dir;
          step_d = 1'b1;
          wrap_d = (nxt_led == load_pattern(mode_q));
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mode_q   <= 2'd0;
      period_q <= 8'd1;
      dir_q    <= DIR_UP;
      presc_q  <= '0;
      cnt_q    <= '0;
      led_q    <= '0;
      busy_q   <= 1'b0;
      step_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      period_q <= period_d;
      dir_q    <= dir_d;
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      led_q    <= led_d;
      busy_q   <= busy_d;
      step_q   <= step_d;
      wrap_q   <= wrap_d;
    end
  end

  assign led    = led_q;
  assign busy_o = busy_q;
  assign step_o = step_q;
  assign wrap_o = wrap_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Testbench for led_seq_ctrl (LED_W=4, DIV=2). A cycle model predicts when
// steps occur (run cycles since the last step against DIV*period); the
// expected led/wrap values of each step are queued at start and popped as the
// DUT reports steps.
module tb_led_seq_ctrl;

  localparam int W   = 4;
  localparam int DIV = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_i = 1'b0;
  logic         stop_i = 1'b0;
  logic         pause_i = 1'b0;
  logic [1:0]   mode_i = 2'd0;
  logic [7:0]   period_i = 8'd1;
  logic [W-1:0] led;
  logic         busy_o;
  logic         step_o;
  logic         wrap_o;

  led_seq_ctrl #(.LED_W(W), .DIV(DIV)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .stop_i   (stop_i),
    .pause_i  (pause_i),
    .mode_i   (mode_i),
    .period_i (period_i),
    .led      (led),
    .busy_o   (busy_o),
    .step_o   (step_o),
    .wrap_o   (wrap_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference pattern: led value after k steps from the load value.
  function automatic logic [W-1:0] exp_led(input logic [1:0] m, input int k);
    int p;
    case (m)
      2'd0: return W'(1 << (k % W));
      2'd1: return W'((1 << (W-1)) >> (k % W));
      2'd2: return ((k % 2) == 0) ? '1 : '0;
      default: begin
        p = k % (2*(W-1));
        if (p > W-1) p = 2*(W-1) - p;
        return W'(1 << p);
      end
    endcase
  endfunction

  function automatic int cyc_len(input logic [1:0] m);
    case (m)
      2'd2:    return 2;
      2'd3:    return 2*(W-1);
      default: return W;
    endcase
  endfunction

  typedef struct {
    logic [W-1:0] led;
    logic         wrap;
  } exp_t;

  exp_t         sb[$];
  exp_t         e;
  logic         m_busy = 1'b0;
  logic         m_paused = 1'b0;
  logic         m_step = 1'b0;
  logic         m_chk_load = 1'b0;
  logic         m_chk_zero = 1'b1;
  int           m_cnt = 0;
  int           m_target = DIV;
  int           m_k = 0;
  logic [1:0]   m_mode = 2'd0;
  logic [W-1:0] m_load = '0;

  function automatic void push_next();
    m_k++;
    sb.push_back('{led: exp_led(m_mode, m_k), wrap: ((m_k % cyc_len(m_mode)) == 0)});
  endfunction

  // Cycle model, advanced at each active edge with the inputs the DUT sees.
  always @(posedge clk or negedge rst_n) begin
    m_step     = 1'b0;
    m_chk_load = 1'b0;
    m_chk_zero = 1'b0;
    if (!rst_n) begin
      m_busy = 1'b0; m_paused = 1'b0; m_cnt = 0; sb.delete(); m_chk_zero = 1'b1;
    end else if (stop_i) begin
      m_busy = 1'b0; m_paused = 1'b0; m_cnt = 0; sb.delete(); m_chk_zero = 1'b1;
    end else if (start_i) begin
      m_busy = 1'b1; m_paused = 1'b0; m_cnt = 0;
      m_mode = mode_i;
      m_target = DIV * ((period_i == 8'd0) ? 1 : int'(period_i));
      m_k = 0;
      sb.delete();
      for (int i = 0; i < 4; i++) push_next();
      m_load = exp_led(mode_i, 0);
      m_chk_load = 1'b1;
    end else if (pause_i) begin
      if (m_busy) m_paused = !m_paused;
    end else if (m_busy && !m_paused) begin
      m_cnt++;
      if (m_cnt == m_target) begin
        m_cnt  = 0;
        m_step = 1'b1;
      end
    end
  end

  // Output monitor on the inactive edge.
  always @(negedge clk) begin
    check("busy", 32'(busy_o), 32'(m_busy));
    check("step", 32'(step_o), 32'(m_step));
    if (step_o) begin
      if (sb.size() == 0) begin
        check("sb_empty", 32'(1), 32'(0));
      end else begin
        e = sb.pop_front();
        check("step_led", 32'(led), 32'(e.led));
        check("wrap", 32'(wrap_o), 32'(e.wrap));
        push_next();
      end
    end else begin
      check("wrap_nostep", 32'(wrap_o), 32'(0));
    end
    if (m_chk_load) check("load_led", 32'(led), 32'(m_load));
    if (m_chk_zero) check("zero_led", 32'(led), 32'(0));
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic cmd(input logic st, input logic sp, input logic pa,
                     input logic [1:0] m, input logic [7:0] p);
    start_i = st; stop_i = sp; pause_i = pa; mode_i = m; period_i = p;
    @(negedge clk);
    #1;
    start_i = 1'b0; stop_i = 1'b0; pause_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    rst_n = 1'b1;
    idle(3);
    cmd(0, 0, 1, 2'd0, 8'd1);          // pause in IDLE: ignored
    idle(3);
    cmd(1, 0, 0, 2'd0, 8'd1);          // flow-left, period 1
    idle(10);
    cmd(1, 0, 0, 2'd1, 8'd2);          // restart while running: flow-right, period 2
    idle(20);
    cmd(1, 0, 0, 2'd2, 8'd0);          // blink, period 0 acts as 1
    idle(10);
    cmd(1, 0, 0, 2'd3, 8'd1);          // ping-pong
    mode_i = 2'd0; period_i = 8'd7;    // changes without start are ignored
    idle(16);
    cmd(1, 0, 0, 2'd0, 8'd3);          // flow-left, period 3, then pause mid-step
    idle(5);
    cmd(0, 0, 1, 2'd0, 8'd3);
    idle(10);
    cmd(0, 0, 1, 2'd0, 8'd3);
    idle(20);
    cmd(1, 0, 1, 2'd2, 8'd1);          // start+pause together: start wins, RUN
    idle(6);
    cmd(0, 0, 1, 2'd2, 8'd1);          // pause, then start while paused
    idle(3);
    cmd(1, 0, 0, 2'd3, 8'd2);
    idle(8);
    cmd(1, 1, 0, 2'd1, 8'd1);          // stop+start together: stop wins
    idle(3);
    cmd(1, 0, 0, 2'd1, 8'd2);          // async reset mid-step in flow-right
    idle(3);
    #2 rst_n = 1'b0;
    #1;
    check("async_led",  32'(led),    32'(0));
    check("async_busy", 32'(busy_o), 32'(0));
    check("async_step", 32'(step_o), 32'(0));
    idle(2);
    rst_n = 1'b1;
    idle(2);
    cmd(1, 0, 0, 2'd1, 8'd1);          // flow-right reload after reset
    idle(10);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
